decode_issue_ctrl: RTL
======================

# decode_issue_ctrl

Decode-stage issue controller between the aligner and the combinational instruction decoder. It buffers aligned instructions in a small FIFO and presents the head entry to the decoder. Using the decoder's source and misconduct outputs, it decides each cycle whether the head issues into the ID/EX register, stalls on a load-use hazard, or halts behind a trapping instruction until a pipeline flush.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- CNT_W, 16, width of the saturating hazard-stall counter
- s_clk_i  in  1  clock
- s_rst_i  in  1  reset, asynchronous, active-high
- s_valid_i  in  1  aligner offers an instruction
- s_ready_o  out  1  FIFO can accept; equals not full
- s_instr_i  in  32  aligned instruction
- s_fetch_error_i  in  3  fetch error code
- s_align_error_i  in  1  alignment error
- s_prediction_i  in  1  prediction made from this instruction
- s_head_valid_o  out  1  head entry present
- s_head_instr_o / s_head_ferr_o / s_head_aerr_o / s_head_pred_o  out  32/3/1/1  head fields, driven to the decoder
- s_dec_rs1_i, s_dec_rs2_i  in  rf_add  decoder read addresses
- s_dec_sctrl_i  in  sctrl  decoder source control
- s_dec_imiscon_i  in  imiscon  decoder misconduct indicator
- s_id_ready_i  in  1  ID/EX register can accept
- s_ex_load_i  in  1  EX stage holds a load
- s_ex_rd_i  in  rf_add  EX-stage destination register
- s_flush_i  in  1  pipeline flush from the control unit
- s_issue_o  out  1  head is written into the ID/EX register this cycle
- s_hazard_o  out  1  head blocked by load-use
- s_halted_o  out  1  controller is in HALT
- s_stall_cnt_o  out  CNT_W  hazard-stall cycles, saturating

## Operation
- FIFO state: read pointer, write pointer and count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Push: s_valid_i & s_ready_o & ~s_flush_i.
- Pop: s_issue_o.
- s_ready_o is derived from the registered count only. When full, no push is accepted, even if a pop occurs in the same cycle.
- Hazard: s_hazard_o = s_head_valid_o & s_ex_load_i & (s_ex_rd_i != 0) & ((sctrl[SCTRL_RFRP1] & s_dec_rs1_i == s_ex_rd_i) | (sctrl[SCTRL_RFRP2] & s_dec_rs2_i == s_ex_rd_i)). It is forced to 0 when s_dec_imiscon_i != IMISCON_FREE, because trapping instructions never wait.
- Issue: s_issue_o = s_head_valid_o & state==RUN & s_id_ready_i & ~s_hazard_o & ~s_flush_i.
- FSM, two states:
  - RUN → HALT when s_issue_o and s_dec_imiscon_i != IMISCON_FREE.
  - HALT → RUN only on s_flush_i.
  - In HALT there is no issue; pushes continue until the FIFO is full.
- Flush has top priority: the FIFO empties (count 0, pointers 0), state goes to RUN, the push in the same cycle is dropped, and no issue occurs.
- s_stall_cnt_o increments on each cycle where s_hazard_o & state==RUN & s_id_ready_i. It saturates at all-ones and is not cleared by flush.

## Timing
- Reset (asynchronous, immediate) values:
  - count, pointers and stall counter = 0.
  - state = RUN.
  - s_ready_o = 1.
  - s_head_valid_o = 0, so s_issue_o = 0 and s_hazard_o = 0.
  - s_halted_o = 0.
- Head fields are held at reset value 0 while the FIFO is empty.
- There is no push-to-head bypass. An instruction pushed in cycle N appears at the head in N+1 and can issue in N+1 at the earliest.
- s_issue_o, s_hazard_o and s_head_* are combinational from registered state plus same-cycle inputs. The decoder path is combinational: head → decoder → s_dec_* → issue, all within one cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- When count==1, a push and a pop in the same cycle leave the new entry at the head in the next cycle.
- A flush in the same cycle as the HALT-entering issue: the flush wins, the issue is suppressed, and state stays RUN.

## Structure
- p_hardisc additions:
  - issue_state enum {ISSUE_RUN, ISSUE_HALT}.
  - Reuse rf_add, sctrl, SCTRL_RFRP1/2, imiscon, IMISCON_FREE.
- Sub-module instr_fifo: parameterised DEPTH storage of {instr, ferr, aerr, pred}. It has push/pop/flush inputs and full/empty/head outputs.
- decode_issue_ctrl contains the FSM, the hazard compare and the stall counter, and instantiates instr_fifo.

## Test plan
- Push 0x00000013 (nop) at cycle 0, s_id_ready_i=1 → s_head_valid_o=1 and s_issue_o=1 at cycle 1; FIFO empty at cycle 2.
- Push two instructions with s_id_ready_i=0 → s_ready_o=0 at cycle 2. A third s_valid_i is held off. Raising s_id_ready_i issues both in order, one per cycle.
- Head 0x00208033 (add x0,x1,x2) with s_ex_load_i=1, s_ex_rd_i=2 → s_hazard_o=1, no issue, stall counter +1 per cycle. Dropping s_ex_load_i → issue the same cycle.
- Head with s_fetch_error_i giving imiscon != FREE, then two further pushes → one issue, s_halted_o=1, and no further issues. s_flush_i → FIFO empty and RUN next cycle.
- Push with s_valid_i=1 together with s_flush_i=1 at count 1 → next cycle count 0; the flushed-cycle instruction never appears at the head.
- Assert s_rst_i mid-stream with count 2 and state HALT → all outputs immediately at reset values; stall counter 0.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue controller.
package decode_issue_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RF_ADD_W = 5;
  localparam int unsigned SCTRL_W  = 6;
  localparam int unsigned FERR_W   = 3;

  // Register-file address as produced by the decoder.
  typedef logic [RF_ADD_W-1:0] rf_add;

  // Decoder source-control bit vector; one bit per operand source.
  typedef logic [SCTRL_W-1:0] sctrl;

  localparam int unsigned SCTRL_RFRP1 = 0;  // operand 1 read from register file
  localparam int unsigned SCTRL_RFRP2 = 1;  // operand 2 read from register file
  localparam int unsigned SCTRL_IMM   = 2;  // operand taken from immediate
  localparam int unsigned SCTRL_PC    = 3;  // operand taken from PC
  localparam int unsigned SCTRL_ZERO1 = 4;  // operand 1 forced to zero
  localparam int unsigned SCTRL_ZERO2 = 5;  // operand 2 forced to zero

  // Instruction misconduct reported by the decoder; anything but FREE traps.
  typedef enum logic [2:0] {
    IMISCON_FREE = 3'd0,
    IMISCON_ILLE = 3'd1,
    IMISCON_DSCR = 3'd2,
    IMISCON_FERR = 3'd3,
    IMISCON_MISA = 3'd4
  } imiscon;

  // Issue controller state.
  typedef enum logic {
    ISSUE_RUN  = 1'b0,
    ISSUE_HALT = 1'b1
  } issue_state;

  // One aligned instruction with its fetch side-band.
  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [FERR_W-1:0] ferr;
    logic              aerr;
    logic              pred;
  } fetch_entry;

endpackage

// File: rtl/decode_issue_ctrl_instr_fifo.sv
// Small circular FIFO holding aligned instructions ahead of the decoder.
module instr_fifo
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_entry wdata,
  output logic       full,
  output logic       empty,
  output fetch_entry head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry          mem [DEPTH];
  logic [PTR_W-1:0]    rptr;
  logic [PTR_W-1:0]    wptr;
  logic [CNT_W-1:0]    count;
  logic                do_push;
  logic                do_pop;

  // Guard against overflow/underflow locally; flush overrides both.
  always_comb begin
    do_push = push & ~full  & ~flush;
    do_pop  = pop  & ~empty & ~flush;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Status and head presentation; head reads as zero while empty.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    head  = empty ? '0 : mem[rptr];
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: buffers aligned instructions, presents the
// head to the decoder and decides issue / load-use stall / halt-on-trap.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              s_clk_i,
  input  logic              s_rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [XLEN-1:0]   s_instr_i,
  input  logic [FERR_W-1:0] s_fetch_error_i,
  input  logic              s_align_error_i,
  input  logic              s_prediction_i,
  output logic              s_head_valid_o,
  output logic [XLEN-1:0]   s_head_instr_o,
  output logic [FERR_W-1:0] s_head_ferr_o,
  output logic              s_head_aerr_o,
  output logic              s_head_pred_o,
  input  rf_add             s_dec_rs1_i,
  input  rf_add             s_dec_rs2_i,
  input  sctrl              s_dec_sctrl_i,
  input  imiscon            s_dec_imiscon_i,
  input  logic              s_id_ready_i,
  input  logic              s_ex_load_i,
  input  rf_add             s_ex_rd_i,
  input  logic              s_flush_i,
  output logic              s_issue_o,
  output logic              s_hazard_o,
  output logic              s_halted_o,
  output logic [CNT_W-1:0]  s_stall_cnt_o
);

  issue_state       state_q;
  issue_state       state_d;
  fetch_entry       wr_entry;
  fetch_entry       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             rs1_match;
  logic             rs2_match;
  logic             stall_inc;
  logic [CNT_W-1:0] stall_q;

  // Pack the incoming instruction and qualify the push; full blocks even
  // when a pop happens in the same cycle.
  always_comb begin
    wr_entry.instr = s_instr_i;
    wr_entry.ferr  = s_fetch_error_i;
    wr_entry.aerr  = s_align_error_i;
    wr_entry.pred  = s_prediction_i;
    push           = s_valid_i & ~fifo_full & ~s_flush_i;
    s_ready_o      = ~fifo_full;
  end

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (s_clk_i),
    .rst   (s_rst_i),
    .push  (push),
    .pop   (s_issue_o),
    .flush (s_flush_i),
    .wdata (wr_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Head fields go straight to the combinational decoder.
  always_comb begin
    s_head_valid_o = ~fifo_empty;
    s_head_instr_o = head.instr;
    s_head_ferr_o  = head.ferr;
    s_head_aerr_o  = head.aerr;
    s_head_pred_o  = head.pred;
  end

  // Load-use comparison of decoded sources against the EX destination.
  always_comb begin
    rs1_match = s_dec_sctrl_i[SCTRL_RFRP1] & (s_dec_rs1_i == s_ex_rd_i);
    rs2_match = s_dec_sctrl_i[SCTRL_RFRP2] & (s_dec_rs2_i == s_ex_rd_i);
  end

  // State register.
  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      state_q <= ISSUE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus issue/hazard decisions; trapping heads never wait and
  // flush beats everything.
  always_comb begin
    state_d    = state_q;
    s_hazard_o = 1'b0;
    s_issue_o  = 1'b0;

    s_hazard_o = s_head_valid_o & s_ex_load_i & (s_ex_rd_i != '0) &
                 (rs1_match | rs2_match) & (s_dec_imiscon_i == IMISCON_FREE);
    s_issue_o  = s_head_valid_o & (state_q == ISSUE_RUN) & s_id_ready_i &
                 ~s_hazard_o & ~s_flush_i;

    if (s_flush_i) begin
      state_d = ISSUE_RUN;
    end else begin
      unique case (state_q)
        ISSUE_RUN: begin
          if (s_issue_o && (s_dec_imiscon_i != IMISCON_FREE)) begin
            state_d = ISSUE_HALT;
          end
        end
        ISSUE_HALT: begin
          state_d = ISSUE_HALT;
        end
        default: begin
          state_d = ISSUE_RUN;
        end
      endcase
    end
  end

  assign s_halted_o = (state_q == ISSUE_HALT);

  // Saturating count of cycles lost to load-use stalls; survives flush.
  always_comb begin
    stall_inc = s_hazard_o & (state_q == ISSUE_RUN) & s_id_ready_i;
  end

  // Stall counter register.
  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign s_stall_cnt_o = stall_q;

endmodule
